correlation_5: RTL and testbench

- Fixed-coefficient 10-tap correlator (dot product) for a 4-bit datapath.
- Each cycle it samples ten unsigned 4-bit samples x_0..x_9 and multiplies each by a constant 4-bit coefficient h_0..h_9.
- Outputs the 12-bit sum of the ten products through a 2-stage register pipeline.
- Used as a leaf arithmetic block inside signal-processing / matched-filter datapaths.

---
 rtl/correlation_pkg.sv | 14 +
 rtl/corr_tap.sv | 26 ++
 rtl/correlation_5.sv | 80 ++++++++
 tb/tb_correlation_5.sv | 109 ++++++++++
 4 files changed

// File: rtl/correlation_pkg.sv
// Shared constants for the fixed-coefficient 10-tap correlator.
package correlation_pkg;

   localparam int DATA_W = 4;
   localparam int PROD_W = 8;
   localparam int OUT_W  = 12;
   localparam int NTAPS  = 10;

   // Default matched-filter template, tap 0 first.
   localparam logic [DATA_W-1:0] H_DEFAULT [NTAPS] = '{
      4'd5, 4'd10, 4'd2, 4'd6, 4'd13, 4'd14, 4'd1, 4'd9, 4'd8, 4'd15
   };

endpackage

// File: rtl/corr_tap.sv
// One correlator tap: sample times a constant coefficient, registered.
module corr_tap
   import correlation_pkg::*;
#(
   parameter logic [DATA_W-1:0] COEF = 4'd1
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic [DATA_W-1:0] i_x,
   output logic [PROD_W-1:0] o_prod
);

   logic [PROD_W-1:0] r_prod_p1;

   // Stage 1: register the constant product; reset flushes it to zero.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_prod_p1 <= '0;
      end else begin
         r_prod_p1 <= PROD_W'(i_x) * PROD_W'(COEF);
      end
   end

   assign o_prod = r_prod_p1;

endmodule

// File: rtl/correlation_5.sv
// Fixed-coefficient 10-tap correlator: registered products, then a
// registered balanced adder tree. Two-clock latency, one result per clock.
module correlation_5
   import correlation_pkg::*;
#(
   parameter logic [DATA_W-1:0] H0 = H_DEFAULT[0],
   parameter logic [DATA_W-1:0] H1 = H_DEFAULT[1],
   parameter logic [DATA_W-1:0] H2 = H_DEFAULT[2],
   parameter logic [DATA_W-1:0] H3 = H_DEFAULT[3],
   parameter logic [DATA_W-1:0] H4 = H_DEFAULT[4],
   parameter logic [DATA_W-1:0] H5 = H_DEFAULT[5],
   parameter logic [DATA_W-1:0] H6 = H_DEFAULT[6],
   parameter logic [DATA_W-1:0] H7 = H_DEFAULT[7],
   parameter logic [DATA_W-1:0] H8 = H_DEFAULT[8],
   parameter logic [DATA_W-1:0] H9 = H_DEFAULT[9]
) (
   output logic [OUT_W-1:0]  out,
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] x_0,
   input  logic [DATA_W-1:0] x_1,
   input  logic [DATA_W-1:0] x_2,
   input  logic [DATA_W-1:0] x_3,
   input  logic [DATA_W-1:0] x_4,
   input  logic [DATA_W-1:0] x_5,
   input  logic [DATA_W-1:0] x_6,
   input  logic [DATA_W-1:0] x_7,
   input  logic [DATA_W-1:0] x_8,
   input  logic [DATA_W-1:0] x_9
);

   localparam logic [DATA_W-1:0] C_COEF [NTAPS] = '{H0, H1, H2, H3, H4, H5, H6, H7, H8, H9};

   logic [DATA_W-1:0] w_x       [NTAPS];
   logic [PROD_W-1:0] w_prod_p1 [NTAPS];
   logic [OUT_W-1:0]  w_l1      [5];
   logic [OUT_W-1:0]  w_l2      [3];
   logic [OUT_W-1:0]  w_l3      [2];
   logic [OUT_W-1:0]  w_sum;
   logic [OUT_W-1:0]  r_sum_p2;

   assign w_x = '{x_0, x_1, x_2, x_3, x_4, x_5, x_6, x_7, x_8, x_9};

   // ---- Stage 1: per-tap registered products ----
   for (genvar g = 0; g < NTAPS; g++) begin : g_tap
      corr_tap #(
         .COEF (C_COEF[g])
      ) u_tap (
         .i_clock (clock),
         .i_reset (reset),
         .i_x     (w_x[g]),
         .o_prod  (w_prod_p1[g])
      );
   end

   // ---- Stage 2: balanced adder tree over the registered products ----
   // Max sum 10*225 = 2250 fits in OUT_W, so every level is OUT_W wide and cannot wrap.
   for (genvar k = 0; k < 5; k++) begin : g_l1
      assign w_l1[k] = OUT_W'(w_prod_p1[2*k]) + OUT_W'(w_prod_p1[2*k+1]);
   end

   assign w_l2[0] = w_l1[0] + w_l1[1];
   assign w_l2[1] = w_l1[2] + w_l1[3];
   assign w_l2[2] = w_l1[4];
   assign w_l3[0] = w_l2[0] + w_l2[1];
   assign w_l3[1] = w_l2[2];
   assign w_sum   = w_l3[0] + w_l3[1];

   // Register the tree result; reset discards any in-flight sum.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_sum_p2 <= '0;
      end else begin
         r_sum_p2 <= w_sum;
      end
   end

   assign out = r_sum_p2;

endmodule

// File: tb/tb_correlation_5.sv
// Directed bench for correlation_5: reset behaviour, single-tap impulses,
// maximum input, back-to-back throughput, random vectors, mid-stream reset.
module tb_correlation_5;

   logic        clock;
   logic        reset;
   logic [11:0] out;
   logic [3:0]  x [10];

   int checks   = 0;
   int failures = 0;

   localparam logic [39:0] V_ZERO  = 40'h0;
   localparam logic [39:0] V_ALL15 = 40'hFFFFFFFFFF;
   localparam logic [39:0] V_ONES  = 40'h1111111111;
   localparam logic [39:0] V_RAMP  = 40'h9876543210;
   localparam logic [39:0] V_X0    = 40'h0000000001;
   localparam logic [39:0] V_X9    = 40'hF000000000;

   correlation_5 dut (
      .out   (out),
      .clock (clock),
      .reset (reset),
      .x_0   (x[0]),
      .x_1   (x[1]),
      .x_2   (x[2]),
      .x_3   (x[3]),
      .x_4   (x[4]),
      .x_5   (x[5]),
      .x_6   (x[6]),
      .x_7   (x[7]),
      .x_8   (x[8]),
      .x_9   (x[9])
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference dot product with the default coefficients.
   function automatic int ref_dot(input logic [39:0] v);
      int h [10];
      int s;
      h = '{5, 10, 2, 6, 13, 14, 1, 9, 8, 15};
      s = 0;
      for (int i = 0; i < 10; i++) s += int'(v[4*i +: 4]) * h[i];
      return s;
   endfunction

   // Drive one vector and reset level, clock once, check out just after the edge.
   task automatic step(input logic [39:0] v, input logic rst, input int exp, input string tag);
      reset = rst;
      for (int i = 0; i < 10; i++) x[i] = v[4*i +: 4];
      @(posedge clock);
      #1;
      checks++;
      assert (out === 12'(exp)) else begin
         failures++;
         $error("FAIL %s out=%0d expected=%0d", tag, out, exp);
      end
   endtask

   initial begin
      logic [39:0] prev;
      logic [39:0] cur;

      reset = 1'b1;
      for (int i = 0; i < 10; i++) x[i] = 4'd0;

      // Reset held two edges, then released with zero inputs.
      step(V_ZERO, 1'b1, 0, "rst_edge0");
      step(V_ZERO, 1'b1, 0, "rst_edge1");
      step(V_ZERO, 1'b0, 0, "post_rst0");
      step(V_ZERO, 1'b0, 0, "post_rst1");

      // Single-tap impulses: result appears exactly two edges after applying.
      step(V_X0,   1'b0, 0,   "x0_lat1");
      step(V_X9,   1'b0, 5,   "x0_out");
      step(V_ZERO, 1'b0, 225, "x9_out");
      step(V_ZERO, 1'b0, 0,   "x9_drain");

      // Maximum, ramp and all-ones back to back: one result per clock.
      step(V_ALL15, 1'b0, 0,    "max_lat1");
      step(V_RAMP,  1'b0, 1245, "max_out");
      step(V_ONES,  1'b0, 422,  "ramp_out");
      step(V_ZERO,  1'b0, 83,   "ones_out");
      step(V_ZERO,  1'b0, 0,    "b2b_drain");

      // Random vectors every cycle.
      prev = V_ZERO;
      for (int n = 0; n < 25; n++) begin
         for (int i = 0; i < 10; i++) cur[4*i +: 4] = 4'($urandom_range(0, 15));
         step(cur, 1'b0, ref_dot(prev), "random");
         prev = cur;
      end
      step(V_ZERO, 1'b0, ref_dot(prev), "random_last");

      // All-15 stream with a one-edge reset in the middle.
      step(V_ALL15, 1'b0, 0,    "mid_fill");
      step(V_ALL15, 1'b0, 1245, "mid_pre");
      step(V_ALL15, 1'b1, 0,    "mid_rst_edge");
      step(V_ALL15, 1'b0, 0,    "mid_rst_next");
      step(V_ALL15, 1'b0, 1245, "mid_resume0");
      step(V_ALL15, 1'b0, 1245, "mid_resume1");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
